// File: rtl/fft_reorder_denorm.sv
// fft_reorder_denorm
//   FFT back-end stage. Each input beat carries LANES complex samples from
//   the last butterfly stage plus a block-floating-point exponent. Every
//   sample is shifted right with round-half-up, saturated to OUT_W and
//   written to a ping-pong frame buffer at its bit-reversed address. Full
//   frames are streamed out in natural order, LANES samples per beat.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready input beat handshake
//   din_R, din_Q      LANES x IN_W signed samples, lane l at [l*IN_W +: IN_W]
//   sf_in             right-shift exponent for the current input beat
//   out_valid/ready   output beat handshake
//   dout_R, dout_Q    LANES x OUT_W signed natural-order samples
//   out_last          final beat of the frame being drained
//   frame_done        one-cycle pulse after the out_last handshake
//   sat_cnt           saturation count of the frame being drained
//                     (only with FFT_REORDER_SAT_CNT_EN defined)
//
// Optional feature macro: FFT_REORDER_SAT_CNT_EN
//
// Bank states (one instance per buffer bank)
//   state          | meaning
//   BANK_EMPTY     | no frame held, writable
//   BANK_FILLING   | write side has accepted part of a frame
//   BANK_FULL      | complete frame held, not yet presented
//   BANK_DRAINING  | frame being streamed out
module fft_reorder_denorm #(
   parameter int N_POINTS = 512,
   parameter int LANES    = 16,
   parameter int IN_W     = 16,
   parameter int OUT_W    = 13,
   parameter int SF_W     = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  din_R,
   input  logic [LANES*IN_W-1:0]  din_Q,
   input  logic [SF_W-1:0]        sf_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] dout_R,
   output logic [LANES*OUT_W-1:0] dout_Q,
   output logic                   out_last,
   output logic                   frame_done
`ifdef FFT_REORDER_SAT_CNT_EN
   ,
   output logic [$clog2(N_POINTS)+1:0] sat_cnt
`endif
);

   localparam int A  = $clog2(N_POINTS);
   localparam int B  = N_POINTS / LANES;
   localparam int BW = (B > 1) ? $clog2(B) : 1;
   localparam int EW = IN_W + 1;
   localparam logic signed [EW-1:0] SAT_MAX = EW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_DRAINING
   } bank_state_t;

   bank_state_t bank_st  [2];
   bank_state_t bank_nxt [2];

   logic          wr_bank;
   logic          rd_bank;
   logic [BW-1:0] wr_cnt;
   logic [BW-1:0] rd_cnt;
   logic          wr_fire;
   logic          rd_fire;
   logic          wr_last;
   logic          rd_last;
   logic          rd_first;
   logic [A-1:0]  wr_base;
   logic [A-1:0]  rd_base;

   logic signed [EW-1:0] sh_r    [LANES];
   logic signed [EW-1:0] sh_q    [LANES];
   logic [OUT_W-1:0]     wr_r    [LANES];
   logic [OUT_W-1:0]     wr_q    [LANES];
   logic [A-1:0]         wr_addr [LANES];

   logic [OUT_W-1:0] mem_r [2][N_POINTS];
   logic [OUT_W-1:0] mem_q [2][N_POINTS];

   function automatic logic [A-1:0] bitrev(input logic [A-1:0] x);
      logic [A-1:0] r;
      for (int b = 0; b < A; b++) r[b] = x[A-1-b];
      return r;
   endfunction

   // Sign-extend by one bit first so the rounding increment cannot wrap.
   function automatic logic signed [EW-1:0] shift_round(input logic signed [IN_W-1:0] x,
                                                         input logic [SF_W-1:0] s);
      logic signed [EW-1:0] ext;
      logic signed [EW-1:0] rnd;
      ext = {x[IN_W-1], x};
      if (s == '0) begin
         return ext;
      end else if (int'(s) >= IN_W) begin
         return '0;
      end
      rnd = ext + (EW'(1) << (s - 1'b1));
      return rnd >>> s;
   endfunction

   function automatic logic [OUT_W-1:0] clamp(input logic signed [EW-1:0] v);
      if (v > SAT_MAX) begin
         return SAT_MAX[OUT_W-1:0];
      end else if (v < SAT_MIN) begin
         return SAT_MIN[OUT_W-1:0];
      end
      return v[OUT_W-1:0];
   endfunction

   // Handshakes and per-bank status

   assign in_ready  = (bank_st[wr_bank] == BANK_EMPTY) || (bank_st[wr_bank] == BANK_FILLING);
   assign out_valid = (bank_st[rd_bank] == BANK_FULL) || (bank_st[rd_bank] == BANK_DRAINING);
   assign wr_fire   = in_valid && in_ready;
   assign rd_fire   = out_valid && out_ready;
   assign wr_last   = (wr_cnt == BW'(B - 1));
   assign rd_last   = (rd_cnt == BW'(B - 1));
   assign rd_first  = out_valid && (bank_st[rd_bank] == BANK_FULL);
   assign out_last  = out_valid && rd_last;
   assign wr_base   = A'(int'(wr_cnt) * LANES);
   assign rd_base   = A'(int'(rd_cnt) * LANES);

   // Write and read banks can never be the same bank while both fire:
   // a write needs EMPTY/FILLING, a presented read needs FULL/DRAINING.
   always_comb begin
      for (int b = 0; b < 2; b++) bank_nxt[b] = bank_st[b];
      if (wr_fire) begin
         bank_nxt[wr_bank] = wr_last ? BANK_FULL : BANK_FILLING;
      end
      if (rd_fire && rd_last) begin
         bank_nxt[rd_bank] = BANK_EMPTY;
      end else if (rd_first) begin
         bank_nxt[rd_bank] = BANK_DRAINING;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) bank_st[b] <= BANK_EMPTY;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         frame_done <= 1'b0;
      end else begin
         for (int b = 0; b < 2; b++) bank_st[b] <= bank_nxt[b];
         if (wr_fire) begin
            if (wr_last) begin
               wr_cnt  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_cnt <= wr_cnt + BW'(1);
            end
         end
         if (rd_fire) begin
            if (rd_last) begin
               rd_cnt  <= '0;
               rd_bank <= ~rd_bank;
            end else begin
               rd_cnt <= rd_cnt + BW'(1);
            end
         end
         frame_done <= rd_fire && rd_last;
      end
   end

   // Write datapath: denormalise, saturate, scatter to bit-reversed address

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         sh_r[l]    = shift_round(din_R[l*IN_W +: IN_W], sf_in);
         sh_q[l]    = shift_round(din_Q[l*IN_W +: IN_W], sf_in);
         wr_r[l]    = clamp(sh_r[l]);
         wr_q[l]    = clamp(sh_q[l]);
         wr_addr[l] = bitrev(wr_base + A'(l));
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int l = 0; l < LANES; l++) begin
            mem_r[wr_bank][wr_addr[l]] <= wr_r[l];
            mem_q[wr_bank][wr_addr[l]] <= wr_q[l];
         end
      end
   end

   // Read datapath: natural order, combinational from the held bank so the
   // first beat is available the cycle after the frame completes. The bank
   // is not written while it is being drained, so dout holds during stalls.

   always_comb begin
      dout_R = '0;
      dout_Q = '0;
      if (out_valid) begin
         for (int m = 0; m < LANES; m++) begin
            dout_R[m*OUT_W +: OUT_W] = mem_r[rd_bank][rd_base + A'(m)];
            dout_Q[m*OUT_W +: OUT_W] = mem_q[rd_bank][rd_base + A'(m)];
         end
      end
   end

`ifdef FFT_REORDER_SAT_CNT_EN
   localparam int CW = A + 2;

   logic [CW-1:0] sat_beat;
   logic [CW-1:0] sat_frame;
   logic [CW-1:0] sat_acc;
   logic [CW-1:0] bank_sat [2];

   always_comb begin
      sat_beat = '0;
      for (int l = 0; l < LANES; l++) begin
         if ((sh_r[l] > SAT_MAX) || (sh_r[l] < SAT_MIN)) sat_beat = sat_beat + CW'(1);
         if ((sh_q[l] > SAT_MAX) || (sh_q[l] < SAT_MIN)) sat_beat = sat_beat + CW'(1);
      end
      sat_frame = ((wr_cnt == '0) ? '0 : sat_acc) + sat_beat;
   end

   // The running count is parked per bank at frame end because the next
   // frame may already be counting by the time this one is presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_acc     <= '0;
         bank_sat[0] <= '0;
         bank_sat[1] <= '0;
         sat_cnt     <= '0;
      end else begin
         if (wr_fire) begin
            sat_acc <= sat_frame;
            if (wr_last) bank_sat[wr_bank] <= sat_frame;
         end
         if (rd_first) sat_cnt <= bank_sat[rd_bank];
      end
   end
`endif

endmodule

// File: tb/tb_fft_reorder_denorm.sv
module tb_fft_reorder_denorm;

   localparam int N_POINTS = 512;
   localparam int LANES    = 16;
   localparam int IN_W     = 16;
   localparam int OUT_W    = 13;
   localparam int SF_W     = 5;
   localparam int A        = 9;
   localparam int B        = N_POINTS / LANES;
   localparam int RW       = LANES * OUT_W;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*IN_W-1:0] din_R;
   logic [LANES*IN_W-1:0] din_Q;
   logic [SF_W-1:0]       sf_in;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic [RW-1:0]         dout_R;
   logic [RW-1:0]         dout_Q;
   logic                  out_last;
   logic                  frame_done;
`ifdef FFT_REORDER_SAT_CNT_EN
   logic [A+1:0]          sat_cnt;
`endif

   fft_reorder_denorm #(
      .N_POINTS(N_POINTS), .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .SF_W(SF_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .din_R(din_R),
      .din_Q(din_Q),
      .sf_in(sf_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .dout_R(dout_R),
      .dout_Q(dout_Q),
      .out_last(out_last),
      .frame_done(frame_done)
`ifdef FFT_REORDER_SAT_CNT_EN
      ,
      .sat_cnt(sat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference model

   int in_r  [N_POINTS];
   int in_q  [N_POINTS];
   int in_sf [B];

   function automatic int model_shift(input int x, input int s);
      int d;
      int t;
      if (s == 0) return x;
      if (s >= IN_W) return 0;
      d = 1 << s;
      t = x + d / 2;
      if (t >= 0) return t / d;
      return -((-t + d - 1) / d);
   endfunction

   function automatic int model_sat(input int x);
      int hi;
      hi = (1 << (OUT_W - 1)) - 1;
      if (x > hi) return hi;
      if (x < -hi - 1) return -hi - 1;
      return x;
   endfunction

   function automatic int bitrev9(input int x);
      int r;
      r = 0;
      for (int b = 0; b < A; b++) if (((x >> b) & 1) != 0) r = r | (1 << (A - 1 - b));
      return r;
   endfunction

   function automatic logic [OUT_W-1:0] to_out(input int v);
      return v[OUT_W-1:0];
   endfunction

   // Output monitor / scoreboard

   logic [RW-1:0] exp_r_q [$];
   logic [RW-1:0] exp_q_q [$];
   logic [RW-1:0] cap_r [B];
   logic [RW-1:0] cap_q [B];
   logic [RW-1:0] er;
   logic [RW-1:0] eq;
   logic [RW-1:0] hold_r;
   logic [RW-1:0] hold_q;
   logic          hold_last;
   bit            hold_chk  = 1'b0;
   bit            fd_exp    = 1'b0;
   int            mon_j     = 0;
   int            fd_count  = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_done || fd_exp) begin
            check("frame_done", frame_done, fd_exp);
            if (frame_done) fd_count++;
         end
         fd_exp = 1'b0;
         if (hold_chk) begin
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_dout_R", dout_R, hold_r);
            check("hold_dout_Q", dout_Q, hold_q);
            check("hold_out_last", out_last, hold_last);
         end
         hold_chk = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_r_q.size() == 0) begin
               check("unexpected_out_beat", 1'b1, 1'b0);
            end else begin
               er = exp_r_q.pop_front();
               eq = exp_q_q.pop_front();
               check("dout_R", dout_R, er);
               check("dout_Q", dout_Q, eq);
               check("out_last", out_last, (mon_j == B - 1));
               cap_r[mon_j] = dout_R;
               cap_q[mon_j] = dout_Q;
               if (mon_j == B - 1) begin
                  mon_j  = 0;
                  fd_exp = 1'b1;
               end else begin
                  mon_j++;
               end
            end
         end else if (out_valid) begin
            hold_chk  = 1'b1;
            hold_r    = dout_R;
            hold_q    = dout_Q;
            hold_last = out_last;
         end else if (out_last) begin
            check("out_last_idle", out_last, 1'b0);
         end
      end
   end

   // Output ready driver (single driver of out_ready)

   bit ready_rand  = 1'b0;
   bit ready_fixed = 1'b0;

   always @(posedge clk) begin
      #1;
      out_ready = ready_rand ? ($urandom_range(0, 99) < 50) : ready_fixed;
   end

   // Stimulus helpers

   task automatic clear_frame();
      for (int i = 0; i < N_POINTS; i++) begin
         in_r[i] = 0;
         in_q[i] = 0;
      end
      for (int k = 0; k < B; k++) in_sf[k] = 0;
   endtask

   task automatic rand_frame();
      for (int i = 0; i < N_POINTS; i++) begin
         in_r[i] = int'($urandom_range(0, 65535)) - 32768;
         in_q[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      for (int k = 0; k < B; k++)
         in_sf[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4));
   endtask

   task automatic push_expected();
      logic [RW-1:0] vr;
      logic [RW-1:0] vq;
      int            i;
      for (int j = 0; j < B; j++) begin
         for (int m = 0; m < LANES; m++) begin
            i = bitrev9(j * LANES + m);
            vr[m*OUT_W +: OUT_W] = to_out(model_sat(model_shift(in_r[i], in_sf[i / LANES])));
            vq[m*OUT_W +: OUT_W] = to_out(model_sat(model_shift(in_q[i], in_sf[i / LANES])));
         end
         exp_r_q.push_back(vr);
         exp_q_q.push_back(vq);
      end
   endtask

   task automatic send_beat(input int k, input int pct);
      int guard;
      bit done;
      guard = 0;
      done  = 1'b0;
      while (!done) begin
         @(posedge clk);
         #1;
         in_valid = ($urandom_range(0, 99) < pct);
         for (int l = 0; l < LANES; l++) begin
            din_R[l*IN_W +: IN_W] = in_r[k*LANES + l][IN_W-1:0];
            din_Q[l*IN_W +: IN_W] = in_q[k*LANES + l][IN_W-1:0];
         end
         sf_in = in_sf[k][SF_W-1:0];
         @(negedge clk);
         if (in_valid && in_ready) begin
            done = 1'b1;
         end else begin
            guard++;
            if (guard > 3000) begin
               check("in_accept_timeout", 1'b1, 1'b0);
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic send_frame(input int nbeats, input int pct);
      push_expected();
      for (int k = 0; k < nbeats; k++) send_beat(k, pct);
   endtask

   task automatic in_idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while ((exp_r_q.size() != 0 || fd_exp) && guard < 20000) begin
         @(posedge clk);
         guard++;
      end
      if (guard >= 20000) check("drain_timeout", 1'b1, 1'b0);
      repeat (2) @(posedge clk);
   endtask

   // Main sequence

   int hs;
   int cyc;
   int cnt;
   bit got;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      din_R    = '0;
      din_Q    = '0;
      sf_in    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_dout_R", dout_R, '0);
      check("rst_dout_Q", dout_Q, '0);
`ifdef FFT_REORDER_SAT_CNT_EN
      check("rst_sat_cnt", sat_cnt, '0);
`endif
      rst = 1'b0;

      // Impulse: natural index 1 lands on output index 256 (beat 16 lane 0)
      ready_fixed = 1'b1;
      fd_count    = 0;
      clear_frame();
      in_r[1] = 100;
      send_frame(B, 100);
      in_idle();
      wait_drain();
      check("impulse_b16_l0_R", cap_r[16][OUT_W-1:0], to_out(100));
      check("impulse_b0_R", cap_r[0], '0);
      check("impulse_frames", fd_count, 1);

      // Rounding: one sample per beat since the exponent is per beat
      clear_frame();
      in_r[0]  = 5;  in_sf[0] = 1;
      in_r[16] = -5; in_sf[1] = 1; in_q[16] = 5;
      in_r[32] = 7;  in_sf[2] = 16;
      in_r[48] = -1; in_sf[3] = 3;
      send_frame(B, 100);
      in_idle();
      wait_drain();
      check("round_p5_s1", cap_r[0][OUT_W-1:0], to_out(3));
      check("round_m5_s1", cap_r[1][OUT_W-1:0], to_out(-2));
      check("round_q5_s1", cap_q[1][OUT_W-1:0], to_out(3));
      check("round_7_s16", cap_r[0][8*OUT_W +: OUT_W], to_out(0));
      check("round_m1_s3", cap_r[1][8*OUT_W +: OUT_W], to_out(0));

      // Saturation
      clear_frame();
      in_r[0] = 8000;
      in_q[0] = -8000;
      send_frame(B, 100);
      in_idle();
      wait_drain();
      check("sat_pos", cap_r[0][OUT_W-1:0], to_out(4095));
      check("sat_neg", cap_q[0][OUT_W-1:0], to_out(-4096));
`ifdef FFT_REORDER_SAT_CNT_EN
      check("sat_cnt", sat_cnt, 2);
`endif

      // Back-pressure: two frames fill both banks, a third is refused
      fd_count    = 0;
      ready_fixed = 1'b0;
      repeat (2) @(posedge clk);
      rand_frame();
      send_frame(B, 100);
      rand_frame();
      send_frame(B, 100);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (in_ready) cnt++;
      end
      check("bp_third_frame_refused", cnt, 0);
      check("bp_frame1_presented", out_valid, 1'b1);
      @(negedge clk);
      in_valid    = 1'b0;
      ready_fixed = 1'b1;
      hs  = 0;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (in_ready) got = 1'b1;
         else if (out_valid && out_ready) hs++;
      end
      check("bp_in_ready_return", got, 1'b1);
      check("bp_drain_beats", hs, B);
      check("bp_drain_cycles", cyc, B + 1);
      check("bp_frame2_gapless", out_valid, 1'b1);
      rand_frame();
      send_frame(B, 100);
      in_idle();
      wait_drain();
      check("bp_frames", fd_count, 3);

      // Random stalls on both sides
      fd_count   = 0;
      ready_rand = 1'b1;
      for (int f = 0; f < 10; f++) begin
         rand_frame();
         send_frame(B, 50);
      end
      in_idle();
      wait_drain();
      check("rand_frames", fd_count, 10);
      ready_rand = 1'b0;

      // Reset mid-operation: one stored frame plus 20 beats of the next
      ready_fixed = 1'b0;
      repeat (2) @(posedge clk);
      rand_frame();
      send_frame(B, 100);
      rand_frame();
      send_frame(20, 100);
      check("pre_reset_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      check("mid_rst_in_ready", in_ready, 1'b1);
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_out_last", out_last, 1'b0);
      check("mid_rst_frame_done", frame_done, 1'b0);
      check("mid_rst_dout_R", dout_R, '0);
      check("mid_rst_dout_Q", dout_Q, '0);
      exp_r_q.delete();
      exp_q_q.delete();
      mon_j    = 0;
      fd_exp   = 1'b0;
      hold_chk = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid || !in_ready) cnt++;
      end
      check("post_rst_no_stale", cnt, 0);
      fd_count    = 0;
      ready_fixed = 1'b1;
      rand_frame();
      send_frame(B, 100);
      in_idle();
      wait_drain();
      check("post_rst_frames", fd_count, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/fft_reorder_denorm.md
Name: fft_reorder_denorm

Overview:
- Final FFT back-end stage that replaces the fixed 512-sample reorder stage.
- Accepts the last butterfly stage's output, LANES complex samples per beat, each beat tagged with its block-floating-point exponent.
- Denormalises each sample (rounded arithmetic shift), saturates it to OUT_W, and scatters it into a ping-pong frame buffer at its bit-reversed address.
- Streams the frame out in natural order, LANES per beat, over a valid/ready handshake. Parametrised in points, lanes and widths.

Parameters:
- N_POINTS, 512, FFT size; power of two, at least LANES.
- LANES, 16, complex samples per beat; power of two.
- IN_W, 16, signed input sample width (R and Q each).
- OUT_W, 13, signed output sample width; must not exceed IN_W.
- SF_W, 5, scale-exponent width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- din_R  in  LANES*IN_W  real parts; lane l at bits [l*IN_W +: IN_W]
- din_Q  in  LANES*IN_W  imaginary parts; same packing as din_R
- sf_in  in  SF_W  right-shift exponent for this beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- dout_R  out  LANES*OUT_W  natural-order real outputs
- dout_Q  out  LANES*OUT_W  natural-order imaginary outputs
- out_last  out  1  high on final beat of a frame
- frame_done  out  1  one-cycle pulse after the final output beat is accepted

Behaviour:
- Reset (asynchronous, active-high): in_ready=1, out_valid=0, out_last=0, frame_done=0, dout_R/dout_Q=0.
  - Both banks go EMPTY; write and read beat counters go to 0; write bank = 0.
  - Buffer contents are don't-care.
  - A reset mid-frame discards all partial and stored frames; nothing is emitted after reset release until a new full frame is written.
- Beats per frame: B = N_POINTS/LANES. Address width: A = log2(N_POINTS).
- Write side, per input handshake on beat k (0..B-1), for each lane l:
  - Natural index i = k*LANES + l.
  - Destination = bitrev_A(i).
  - Value = sat_OUT_W(rshift(din, sf_in)).
- rshift(x, s):
  - s=0: x unchanged.
  - 0 < s < IN_W: (x + 2^(s-1)) >>> s, evaluated at IN_W+1 bits so the rounding add cannot overflow.
  - s >= IN_W: result 0.
- sat_OUT_W: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Applied independently to R and Q.
- Bank state machine, per bank: EMPTY -> FILLING (first accepted beat) -> FULL (beat B-1 accepted) -> DRAINING (first output beat presented) -> EMPTY (beat B-1 accepted downstream).
- Write pointer toggles banks on the beat B-1 handshake.
- in_ready = 0 only while the write bank is FULL or DRAINING. Both banks busy stalls input.
- Read side:
  - out_valid rises the cycle after the beat B-1 input handshake when the read bank is idle; otherwise it rises the cycle after the previous frame's final output handshake.
  - Output beat j presents natural indices j*LANES .. j*LANES+LANES-1.
  - dout and out_last hold stable while out_valid && !out_ready.
  - out_last = out_valid && (j == B-1).
  - frame_done pulses the cycle after the out_last handshake.
- Simultaneous events: draining one bank and filling the other in the same cycle is legal, with full throughput of 1 beat/cycle on each side.
  - A bank freed by a final output handshake is writable on the next cycle. A same-cycle write to that bank is not allowed.
- in_valid low mid-frame pauses the write counter. No timeout applies.

Optional Feature:
- Macro FFT_REORDER_SAT_CNT_EN.
- When defined:
  - Extra output sat_cnt, width A+2.
  - Counts saturated scalar values (R and Q separately) in the frame being written.
  - Latched into sat_cnt when that frame's first output beat is presented; held until the next latch.
  - Counter clears at each frame start. Reset value is 0.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Impulse, defaults: beat 0 lane 1 R=100, all other samples 0, sf_in=0 -> output beat 16 lane 0 R=100 (bitrev9(1)=256); all other outputs 0; out_last on beat 31; frame_done one cycle later.
- Rounding: R=5, sf_in=1 -> 3; R=-5, sf_in=1 -> -2; R=7, sf_in=16 -> 0; R=-1, sf_in=3 -> 0.
- Saturation: R=8000, Q=-8000, sf_in=0 -> 4095 / -4096. With the macro, sat_cnt=2 for that frame.
- Back-pressure:
  - Stimulus: three frames offered back-to-back with out_ready=0.
  - Required: in_ready drops after the 64th accepted beat and no third-frame beat is accepted.
  - Then raise out_ready: frame 1 drains for 32 cycles, in_ready returns the cycle after frame 1's last handshake, and frame 2 follows gaplessly with dout stable during stalls.
- Random stall: random in_valid/out_ready at 50%, 10 frames of random data and sf_in -> every output matches a reference model (bit-reverse, round, saturate); exactly 10 frame_done pulses.
- Reset mid-operation: assert rst after 20 beats of frame 1 -> outputs reach reset values immediately; after release a clean frame is output correctly with no stale data.
